// File: rtl/mips_imem_loader.sv
// rtl/mips_imem_loader.sv - encodes MIPS instruction descriptors and streams them into imem
// Accepts one descriptor per handshake; rejected opcode/funct pairs set a sticky flag instead of writing.

`ifndef OP_OTHER0
`define OP_OTHER0 6'h00
`define OP_J      6'h02
`define OP_BEQ    6'h04
`define OP_BNE    6'h05
`define OP_ADDI   6'h08
`define OP_ANDI   6'h0C
`define OP_ORI    6'h0D
`define OP_XORI   6'h0E
`define OP_LUI    6'h0F
`define OP_LW     6'h23
`define OP_LBU    6'h24
`define OP_SB     6'h28
`define OP_SW     6'h2B
`define OP0_JR    6'h08
`define OP0_ADD   6'h20
`define OP0_SUB   6'h22
`define OP0_AND   6'h24
`define OP0_OR    6'h25
`define OP0_XOR   6'h26
`define OP0_NOR   6'h27
`define OP0_SLT   6'h2A
`define OP0_ADDM  6'h2C
`endif

module mips_imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        finish,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic [15:0] count,
  output logic        done,
  output logic        bad_instr
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [15:0] LAST_IDX = 16'(DEPTH - 1);

  state_t      state;
  logic        supported;
  logic [31:0] enc_word;

  // Supported set mirrors mips_decode exactly; anything else would trap there.
  always_comb begin
    supported = 1'b0;
    enc_word  = 32'h0;
    case (opcode)
      `OP_OTHER0: begin
        case (funct)
          `OP0_ADD, `OP0_SUB, `OP0_AND, `OP0_OR, `OP0_NOR,
          `OP0_XOR, `OP0_SLT, `OP0_ADDM: begin
            supported = 1'b1;
            enc_word  = {opcode, rs, rt, rd, 5'b0, funct};
          end
          `OP0_JR: begin
            supported = 1'b1;
            enc_word  = {opcode, rs, 5'b0, 5'b0, 5'b0, funct};
          end
          default: begin
            supported = 1'b0;
            enc_word  = 32'h0;
          end
        endcase
      end
      `OP_ADDI, `OP_ANDI, `OP_ORI, `OP_XORI, `OP_BEQ, `OP_BNE,
      `OP_LW, `OP_LBU, `OP_SW, `OP_SB: begin
        supported = 1'b1;
        enc_word  = {opcode, rs, rt, imm};
      end
      `OP_LUI: begin
        supported = 1'b1;
        enc_word  = {opcode, 5'b0, rt, imm};
      end
      `OP_J: begin
        supported = 1'b1;
        enc_word  = {opcode, target};
      end
      default: begin
        supported = 1'b0;
        enc_word  = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      imem_we   <= 1'b0;
      imem_addr <= BASE_ADDR;
      imem_data <= 32'h0;
      count     <= 16'h0;
      done      <= 1'b0;
      bad_instr <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            in_ready  <= 1'b1;
            count     <= 16'h0;
            done      <= 1'b0;
            bad_instr <= 1'b0;
          end
        end
        LOAD: begin
          if (start) begin
            // Restart: drop whatever is on the input this cycle.
            count     <= 16'h0;
            done      <= 1'b0;
            bad_instr <= 1'b0;
          end else begin
            if (in_valid) begin
              if (supported) begin
                imem_we   <= 1'b1;
                imem_addr <= BASE_ADDR + {14'h0, count, 2'b00};
                imem_data <= enc_word;
                count     <= count + 16'd1;
                if (count == LAST_IDX) begin
                  state    <= DONE;
                  in_ready <= 1'b0;
                  done     <= 1'b1;
                end
              end else begin
                bad_instr <= 1'b1;
              end
            end
            if (finish) begin
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mips_imem_loader.md
Name: mips_imem_loader

Overview:
- Instruction-side producer for `mips_decode`: encodes instruction descriptors into 32-bit MIPS words and streams them into instruction memory.
- Sits between the testbench/boot host and the imem write port.
- Accepts one descriptor per valid/ready handshake and assigns sequential word addresses.
- Rejects any opcode/funct pair that `mips_decode` would flag with `except`.

Parameters:
- BASE_ADDR, 32'h0040_0000, byte address of the first written word.
- DEPTH, 1024, maximum number of words per load session (1..65535).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a new load session.
- finish  in  1  pulse; ends the session.
- in_valid  in  1  descriptor present.
- in_ready  out  1  loader accepts a descriptor this cycle.
- opcode  in  6  instruction opcode, using the `OP_*` defines.
- funct  in  6  R-type function code (`OP0_*`); ignored unless opcode==`OP_OTHER0`.
- rs, rt, rd  in  5 each  register fields.
- imm  in  16  I-type immediate.
- target  in  26  J-type target field.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  32  byte address of the write.
- imem_data  out  32  encoded instruction.
- count  out  16  words written in the current session.
- done  out  1  session closed (finished or full).
- bad_instr  out  1  sticky: at least one descriptor was rejected this session.

Behaviour:
- Reset (async, any state): state=IDLE. in_ready, imem_we, count, done and bad_instr all 0. imem_addr=BASE_ADDR, imem_data=0. No write is issued.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: in_ready=0. start -> LOAD.
  - LOAD: in_ready=1.
  - DONE: in_ready=0, done=1. start -> LOAD.
- Entering LOAD from any state: count=0, bad_instr=0, done=0.
- start while in LOAD restarts the session: count=0, no write that cycle, and any in_valid is ignored.
- Handshake: a descriptor is accepted on an edge where in_valid & in_ready.
- Encoding, registered: imem_we=1 and imem_data/imem_addr update in the cycle after acceptance (latency 1).
- imem_addr = BASE_ADDR + 4*count, using count before the increment. count increments on the same edge.
- Supported set, exactly the decoder's:
  - R-type: add, sub, and, or, nor, xor, slt, jr, addm.
  - I-type: addi, andi, ori, xori, beq, bne, lui, lw, lbu, sw, sb.
  - J-type: j.
- Format and field rules:
  - R: {opcode, rs, rt, rd, 5'b0, funct}.
  - jr: rt and rd are forced to 0.
  - I: {opcode, rs, rt, imm}.
  - lui: rs is forced to 0.
  - J: {opcode, target}.
- Unsupported opcode, or an unsupported funct under `OP_OTHER0`:
  - The descriptor is still accepted (handshake completes).
  - No write: imem_we=0 next cycle.
  - count unchanged; bad_instr set to 1 and held until the next start or reset.
- Full: after the accepted descriptor that makes count==DEPTH, the state is DONE on that same edge.
- finish in LOAD -> DONE. If in_valid is also high that cycle, the descriptor is still accepted and encoded, then the state goes to DONE.
- finish in IDLE or DONE is ignored.
- start and finish high together: start wins.
- imem_we is never high for more than one cycle per accepted descriptor.
- count saturates at DEPTH.

Test Plan:
- Reset, start, then `add rd=3, rs=1, rt=2` -> next cycle imem_we=1, imem_addr=0x00400000, imem_data=0x00221820, count=1.
- Back-to-back in_valid: `addi rt=8, rs=0, imm=5` then `j target=0x0100000` -> 0x20080005 at 0x00400000 and 0x08100000 at 0x00400004, on consecutive cycles.
- opcode=6'h3F, then `lui rt=4, imm=0x1234, rs=7` -> first descriptor: no write, bad_instr=1. lui: data=0x3C041234 (rs forced 0) at 0x00400000.
- DEPTH=4, six valid descriptors -> exactly 4 writes. done=1 and in_ready=0 after the fourth acceptance; count=4.
- finish with in_valid (`jr rs=31`) -> write 0x03E00008, then done=1. A later start clears count, done and bad_instr.
- Reset asserted mid-LOAD, between acceptance and write -> outputs go to 0/BASE_ADDR asynchronously, no imem_we pulse, state IDLE.
